// File: rtl/bcd_button_entry.sv
// rtl/bcd_button_entry.sv - four-digit BCD operand entry from active-low push buttons
module bcd_button_entry #(
    parameter int DEB_CYCLES   = 500000,
    parameter int REP_DELAY    = 25000000,
    parameter int REP_RATE     = 5000000,
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  button_mb,
    output logic [15:0] digits,
    output logic [1:0]  sel,
    output logic [3:0]  sel_onehot,
    output logic        blink,
    output logic [15:0] value_out,
    output logic        value_valid
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int RW = $clog2(((REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE) + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REP_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REP_RATE - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    typedef enum logic {S_EDIT, S_COMMIT} state_t;

    // Button bit meanings inside the event vector.
    localparam int B_INC    = 0;
    localparam int B_DEC    = 1;
    localparam int B_NEXT   = 2;
    localparam int B_COMMIT = 3;

    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    btn_s;
    logic [DW-1:0] deb_cnt_q [4];
    logic [DW-1:0] deb_cnt_d [4];
    logic [3:0]    level_q, level_d;
    logic [3:0]    press_q, press_d;
    logic [RW-1:0] rep_cnt_q [2];
    logic [RW-1:0] rep_cnt_d [2];
    logic [1:0]    rep_phase_q, rep_phase_d;
    logic [1:0]    rep_ev_q, rep_ev_d;
    logic [3:0]    ev;

    state_t        state_q;
    logic [15:0]   digits_q;
    logic [1:0]    sel_q;
    logic [1:0]    sel_nxt;
    logic [3:0]    sel_onehot_q;
    logic          blink_q;
    logic [BW-1:0] blink_cnt_q;
    logic [15:0]   value_out_q;
    logic          value_valid_q;
    logic [3:0]    cur_digit;

    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] bcd_dec(input logic [3:0] d);
        return ((d == 4'd0) || (d > 4'd9)) ? 4'd9 : d - 4'd1;
    endfunction

    // Two-flop synchroniser; resets to the released (high) raw level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= button_mb;
            sync2_q <= sync1_q;
        end
    end

    assign btn_s = ~sync2_q;

    // Debounce: count consecutive disagreeing cycles, flip the accepted level at the limit.
    always_comb begin
        level_d = level_q;
        press_d = '0;
        for (int i = 0; i < 4; i++) begin
            deb_cnt_d[i] = '0;
            if (btn_s[i] != level_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    level_d[i] = btn_s[i];
                    press_d[i] = btn_s[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Auto-repeat timers for inc/dec: first repeat after REP_DELAY, then every REP_RATE.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rep_cnt_d[i]   = rep_cnt_q[i];
            rep_phase_d[i] = rep_phase_q[i];
            rep_ev_d[i]    = 1'b0;
            if (press_d[i]) begin
                rep_cnt_d[i]   = '0;
                rep_phase_d[i] = 1'b0;
            end else if (level_q[i] && level_d[i]) begin
                if (rep_cnt_q[i] == (rep_phase_q[i] ? RATE_LAST : DELAY_LAST)) begin
                    rep_cnt_d[i]   = '0;
                    rep_phase_d[i] = 1'b1;
                    rep_ev_d[i]    = 1'b1;
                end else begin
                    rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
                end
            end else begin
                rep_cnt_d[i]   = '0;
                rep_phase_d[i] = 1'b0;
            end
        end
    end

    // Register debounce and repeat state; reset leaves every button released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q     <= '0;
            press_q     <= '0;
            rep_phase_q <= '0;
            rep_ev_q    <= '0;
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
            for (int i = 0; i < 2; i++) rep_cnt_q[i] <= '0;
        end else begin
            level_q     <= level_d;
            press_q     <= press_d;
            rep_phase_q <= rep_phase_d;
            rep_ev_q    <= rep_ev_d;
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
            for (int i = 0; i < 2; i++) rep_cnt_q[i] <= rep_cnt_d[i];
        end
    end

    assign ev        = press_q | {2'b00, rep_ev_q};
    assign cur_digit = digits_q[{sel_q, 2'b00} +: 4];
    assign sel_nxt   = sel_q + 2'd1;

    // Edit/commit FSM with the blink generator, which restarts whenever sel moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_EDIT;
            digits_q      <= '0;
            sel_q         <= '0;
            sel_onehot_q  <= 4'b0001;
            blink_q       <= 1'b0;
            blink_cnt_q   <= '0;
            value_out_q   <= '0;
            value_valid_q <= 1'b0;
        end else begin
            value_valid_q <= 1'b0;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q <= '0;
                blink_q     <= ~blink_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
            case (state_q)
                S_EDIT: begin
                    if (ev[B_COMMIT]) begin
                        state_q       <= S_COMMIT;
                        value_out_q   <= digits_q;
                        value_valid_q <= 1'b1;
                    end else if (ev[B_NEXT]) begin
                        sel_q        <= sel_nxt;
                        sel_onehot_q <= 4'b0001 << sel_nxt;
                        blink_cnt_q  <= '0;
                        blink_q      <= 1'b1;
                    end else if (ev[B_INC] ^ ev[B_DEC]) begin
                        digits_q[{sel_q, 2'b00} +: 4] <= ev[B_INC] ? bcd_inc(cur_digit)
                                                                   : bcd_dec(cur_digit);
                    end
                end
                S_COMMIT: state_q <= S_EDIT;
                default:  state_q <= S_EDIT;
            endcase
        end
    end

    assign digits      = digits_q;
    assign sel         = sel_q;
    assign sel_onehot  = sel_onehot_q;
    assign blink       = blink_q;
    assign value_out   = value_out_q;
    assign value_valid = value_valid_q;

endmodule
